// File: rtl/ama_riscv_imm_sched_if.sv
// Immediate-select type and the fetch/decode handshake bundle
// for the immediate-generator scheduler.
package ama_riscv_imm_sched_pkg;
    typedef enum logic [2:0] {
        IG_DISABLED = 3'd0,
        IG_I_TYPE   = 3'd1,
        IG_S_TYPE   = 3'd2,
        IG_B_TYPE   = 3'd3,
        IG_J_TYPE   = 3'd4,
        IG_U_TYPE   = 3'd5
    } ig_sel_t;
endpackage

interface ama_riscv_imm_sched_if #(
    parameter int PC_W = 32
);
    import ama_riscv_imm_sched_pkg::*;

    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_inst;
    logic [PC_W-1:0] if_pc;
    logic            id_valid;
    logic            id_ready;
    ig_sel_t         ig_sel;
    logic [24:0]     ig_d_in;
    logic [PC_W-1:0] id_pc;
    logic            id_illegal;

    modport master (
        output if_valid, if_inst, if_pc, id_ready,
        input  if_ready, id_valid, ig_sel, ig_d_in, id_pc, id_illegal
    );

    modport slave (
        input  if_valid, if_inst, if_pc, id_ready,
        output if_ready, id_valid, ig_sel, ig_d_in, id_pc, id_illegal
    );
endinterface

// File: rtl/ama_riscv_imm_sched.sv
// Decode front end: 2-entry skid buffer that decodes the opcode
// into an immediate select and presents it registered.
module ama_riscv_imm_sched
    import ama_riscv_imm_sched_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    ama_riscv_imm_sched_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        ig_sel_t         sel;
        logic [24:0]     d;
        logic [PC_W-1:0] pc;
        logic            ill;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_ent;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] ill_q, ill_d;
    logic             in_fire;
    logic             out_fire;

    // Opcode decode of the incoming word
    always_comb begin
        in_ent.d   = bus.if_inst[31:7];
        in_ent.pc  = bus.if_pc;
        in_ent.sel = IG_DISABLED;
        in_ent.ill = 1'b0;
        case (bus.if_inst[6:0])
            7'b0110111,
            7'b0010111: in_ent.sel = IG_U_TYPE;
            7'b1101111: in_ent.sel = IG_J_TYPE;
            7'b1100111,
            7'b0000011,
            7'b0010011,
            7'b1110011: in_ent.sel = IG_I_TYPE;
            7'b0100011: in_ent.sel = IG_S_TYPE;
            7'b1100011: in_ent.sel = IG_B_TYPE;
            7'b0110011,
            7'b0001111: in_ent.sel = IG_DISABLED;
            default:    in_ent.ill = 1'b1;
        endcase
    end

    assign bus.if_ready   = (state_q != FULL);
    assign bus.id_valid   = (state_q != EMPTY);
    assign in_fire        = bus.if_valid & bus.if_ready;
    assign out_fire       = bus.id_valid & bus.id_ready;
    assign bus.ig_sel     = bus.id_valid ? main_q.sel : IG_DISABLED;
    assign bus.ig_d_in    = main_q.d;
    assign bus.id_pc      = main_q.pc;
    assign bus.id_illegal = bus.id_valid & main_q.ill;
    assign stall_cnt      = stall_q;
    assign illegal_cnt    = ill_q;

    // Buffer occupancy and entry movement
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_ent;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_ent;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_ent;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // Saturating stall and illegal-transfer counters
    always_comb begin
        stall_d = stall_q;
        ill_d   = ill_q;
        if (bus.id_valid && !bus.id_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (out_fire && bus.id_illegal && (ill_q != '1)) begin
            ill_d = ill_q + 1'b1;
        end
    end

    // State, buffer and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
            ill_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
            ill_q   <= ill_d;
        end
    end

endmodule
